qspi_flash_responder: RTL and testbench
=======================================

QSPI_FLASH_RESPONDER -- requirements
Module: qspi_flash_responder

Interface
REQ-001 SHALL have parameter SRAM_ADDRESS_SIZE, default 9, giving the backing SRAM word-address width (2^(SRAM_ADDRESS_SIZE+2) bytes).
REQ-002 SHALL have ports: wb_clk_i  input  1  system clock; the only clock in the block.
REQ-003 SHALL have ports: wb_rst_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports: flash_csb  input  1  chip select from initiator, active-low.
REQ-005 SHALL have ports: flash_sck  input  1  serial clock from initiator, asynchronous to wb_clk_i.
REQ-006 SHALL have ports: flash_io0_read  input  1  serial data in (initiator to responder).
REQ-007 SHALL have ports: flash_io1_we  output  1  pad output enable for io1.
REQ-008 SHALL have ports: flash_io1_write  output  1  serial data out (responder to initiator).
REQ-009 SHALL have ports: sram_clk1  output  1  SRAM read clock, equal to wb_clk_i.
REQ-010 SHALL have ports: sram_csb1  output  1  SRAM read select, active-low.
REQ-011 SHALL have ports: sram_addr1  output  SRAM_ADDRESS_SIZE  SRAM word address.
REQ-012 SHALL have ports: sram_dout1  input  32  SRAM read data, valid one wb_clk_i cycle after select.
REQ-013 SHALL have ports: cmd_error  output  1  one-cycle pulse on unsupported command.

Function
REQ-014 SHALL pass flash_csb, flash_sck and flash_io0_read through 2-flop synchronisers; all edge detection uses synchronised values.
REQ-015 SHALL sample io0 on each synchronised sck rising edge and update io1 on each synchronised sck falling edge; MSB first.
REQ-016 SHALL require sck high and low times each >= 3 wb_clk_i cycles; faster sck is unsupported.
REQ-017 SHALL implement states IDLE, COMMAND (8 bits), ADDRESS (24 bits), DUMMY (8 bits), DATA, IGNORE.
REQ-018 SHALL go IDLE->COMMAND on csb falling edge, with bit counter cleared.
REQ-019 SHALL accept command 0x03 (READ): COMMAND->ADDRESS->DATA.
REQ-020 SHALL treat any other command as unsupported: pulse cmd_error for one cycle, enter IGNORE until csb rises.
REQ-021 SHALL use byte address bits [SRAM_ADDRESS_SIZE+1:0]; higher address bits ignored (aliasing).
REQ-022 SHALL map bytes little-endian in a word: byte offset 0 = sram_dout1[7:0], offset 3 = [31:24].
REQ-023 SHALL issue an SRAM read (sram_csb1 low one cycle) on the sck rising edge that samples the last address/dummy bit, and thereafter on the rising edge sampling bit 0 of each byte at offset 3.
REQ-024 SHALL drive data bit 7 of the first byte on the sck falling edge immediately following the last address/dummy bit.
REQ-025 SHALL increment the byte address after each 8 data bits; wrap from the top byte to byte 0.
REQ-026 SHALL drive flash_io1_we = 1 only in DATA with csb low; 0 otherwise, flash_io1_write = 0 when not driving.
REQ-027 SHALL return to IDLE within 3 cycles of a csb rising edge from any state, aborting partial transfers without error.

Reset
REQ-028 SHALL, while wb_rst_i = 1 at a clock edge, enter IDLE with flash_io1_we = 0, flash_io1_write = 0, sram_csb1 = 1, sram_addr1 = 0, cmd_error = 0, counters and synchroniser flops cleared (csb syncs to 1).
REQ-029 SHALL, after reset released mid-transfer (csb already low), stay IDLE until a fresh csb falling edge.

Configuration
REQ-030 SHALL, with QSPI_RESPONDER_FAST_READ_EN defined, accept 0x0B (FAST READ): COMMAND->ADDRESS->DUMMY (8 sck)->DATA.
REQ-031 SHALL, without QSPI_RESPONDER_FAST_READ_EN, treat 0x0B as unsupported per REQ-020 and omit DUMMY state logic.

Structure
REQ-032 SHALL place command opcodes (0x03, 0x0B), state encoding and bit-count constants (8, 24, 8) in shared package qspi_flash_pkg.
REQ-033 SHALL use one sub-module, qspi_input_sync, for synchronisers and sck edge detection.

Verification
REQ-034 SHALL test: SRAM word0 = 0x44332211, READ 0x03 addr 0x000000, 4 bytes -> io1 bytes 0x11,0x22,0x33,0x44.
REQ-035 SHALL test: word511 = 0xAA000000, word0 = 0x000000BB, READ addr 0x0007FF, 2 bytes -> 0xAA then 0xBB (wrap).
REQ-036 SHALL test: command 0x9F -> cmd_error single pulse, flash_io1_we stays 0, subsequent READ correct.
REQ-037 SHALL test: csb raised after 12 address bits -> IDLE, no SRAM read, next READ addr 0x000004 returns word1 bytes correctly.
REQ-038 SHALL test: 0x0B addr 0x000000 with 8 dummy clocks -> 0x11 with macro; cmd_error pulse without macro.
REQ-039 SHALL test: wb_rst_i asserted mid-DATA -> next cycle flash_io1_we = 0, sram_csb1 = 1; no output until new csb fall.

Source files
------------

// File: rtl/qspi_flash_pkg.sv
// Shared opcodes, bit counts and state encoding for the QSPI flash responder.
// The FAST READ opcode is only decoded when QSPI_RESPONDER_FAST_READ_EN is set.
package qspi_flash_pkg;

    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;

    localparam int CMD_BITS   = 8;
    localparam int ADDR_BITS  = 24;
    localparam int DUMMY_BITS = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COMMAND,
        S_ADDRESS,
        S_DUMMY,
        S_DATA,
        S_IGNORE
    } state_t;

    // Little-endian byte lane within a 32-bit SRAM word
    function automatic logic [7:0] byte_sel(
        input logic [31:0] w,
        input logic [1:0]  off
    );
        logic [7:0] b;
        unique case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/qspi_input_sync.sv
// Two-flop synchronisers for the flash pins plus sck/csb edge detection.
// A csb fall is only reported once csb has been seen high after reset.
module qspi_input_sync (
    input  logic clk,
    input  logic rst,
    input  logic csb,
    input  logic sck,
    input  logic io0,
    output logic csb_s,
    output logic io0_s,
    output logic csb_fall,
    output logic sck_rise,
    output logic sck_fall
);

    logic [1:0] csb_ff;
    logic [1:0] sck_ff;
    logic [1:0] io0_ff;
    logic       csb_prev;
    logic       sck_prev;
    logic [1:0] settle;
    logic       armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            csb_ff   <= 2'b11;
            sck_ff   <= 2'b00;
            io0_ff   <= 2'b00;
            csb_prev <= 1'b1;
            sck_prev <= 1'b0;
            settle   <= 2'b00;
            armed    <= 1'b0;
        end else begin
            csb_ff   <= {csb_ff[0], csb};
            sck_ff   <= {sck_ff[0], sck};
            io0_ff   <= {io0_ff[0], io0};
            csb_prev <= csb_ff[1];
            sck_prev <= sck_ff[1];
            settle   <= {settle[0], 1'b1};
            // Arm only once the pipeline holds a real, high csb sample
            if (settle[1] && csb_ff[1])
                armed <= 1'b1;
        end
    end

    assign csb_s    = csb_ff[1];
    assign io0_s    = io0_ff[1];
    assign csb_fall = armed & csb_prev & ~csb_ff[1];
    assign sck_rise = ~sck_prev & sck_ff[1];
    assign sck_fall = sck_prev & ~sck_ff[1];

endmodule

// File: rtl/qspi_flash_responder.sv
// SPI flash read responder serving bytes from a 32-bit SRAM port.
// Define QSPI_RESPONDER_FAST_READ_EN to also accept FAST READ (0x0B).
module qspi_flash_responder
    import qspi_flash_pkg::*;
#(
    parameter int SRAM_ADDRESS_SIZE = 9
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_i,
    input  logic                         flash_csb,
    input  logic                         flash_sck,
    input  logic                         flash_io0_read,
    output logic                         flash_io1_we,
    output logic                         flash_io1_write,
    output logic                         sram_clk1,
    output logic                         sram_csb1,
    output logic [SRAM_ADDRESS_SIZE-1:0] sram_addr1,
    input  logic [31:0]                  sram_dout1,
    output logic                         cmd_error
);

    localparam int AW = SRAM_ADDRESS_SIZE + 2;

    logic csb_s;
    logic io0_s;
    logic csb_fall;
    logic sck_rise;
    logic sck_fall;

    state_t                       state, state_n;
    logic [4:0]                   bit_cnt, bit_cnt_n;
    logic [6:0]                   cmd, cmd_n;
    logic [AW-1:0]                addr, addr_n;
    logic [31:0]                  word;
    logic                         rd_pend;
    logic                         io1_we_n;
    logic                         io1_write_n;
    logic                         sram_csb1_n;
    logic [SRAM_ADDRESS_SIZE-1:0] sram_addr1_n;
    logic                         cmd_error_n;
    logic [7:0]                   cmd_in;
    logic [AW-1:0]                addr_in;
    logic [AW-1:0]                addr_inc;
    logic [7:0]                   tx_byte;
    logic                         to_dummy;
`ifdef QSPI_RESPONDER_FAST_READ_EN
    logic                         fast, fast_n;
`endif

    qspi_input_sync u_sync (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .csb      (flash_csb),
        .sck      (flash_sck),
        .io0      (flash_io0_read),
        .csb_s    (csb_s),
        .io0_s    (io0_s),
        .csb_fall (csb_fall),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall)
    );

    assign sram_clk1 = wb_clk_i;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state           <= S_IDLE;
            bit_cnt         <= '0;
            cmd             <= '0;
            addr            <= '0;
            word            <= '0;
            rd_pend         <= 1'b0;
            flash_io1_we    <= 1'b0;
            flash_io1_write <= 1'b0;
            sram_csb1       <= 1'b1;
            sram_addr1      <= '0;
            cmd_error       <= 1'b0;
`ifdef QSPI_RESPONDER_FAST_READ_EN
            fast            <= 1'b0;
`endif
        end else begin
            state           <= state_n;
            bit_cnt         <= bit_cnt_n;
            cmd             <= cmd_n;
            addr            <= addr_n;
            rd_pend         <= ~sram_csb1;
            flash_io1_we    <= io1_we_n;
            flash_io1_write <= io1_write_n;
            sram_csb1       <= sram_csb1_n;
            sram_addr1      <= sram_addr1_n;
            cmd_error       <= cmd_error_n;
`ifdef QSPI_RESPONDER_FAST_READ_EN
            fast            <= fast_n;
`endif
            // SRAM data lands one cycle after the select pulse
            if (rd_pend)
                word <= sram_dout1;
        end
    end

    assign cmd_in   = {cmd, io0_s};
    assign addr_in  = {addr[AW-2:0], io0_s};
    assign addr_inc = addr + AW'(1);
    assign tx_byte  = byte_sel(word, addr[1:0]);

`ifdef QSPI_RESPONDER_FAST_READ_EN
    assign to_dummy = fast;
`else
    assign to_dummy = 1'b0;
`endif

    always_comb begin
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        cmd_n        = cmd;
        addr_n       = addr;
        sram_csb1_n  = 1'b1;
        sram_addr1_n = sram_addr1;
        cmd_error_n  = 1'b0;
        io1_write_n  = flash_io1_write;
`ifdef QSPI_RESPONDER_FAST_READ_EN
        fast_n       = fast;
`endif
        unique case (state)
            S_IDLE: begin
                if (csb_fall) begin
                    state_n   = S_COMMAND;
                    bit_cnt_n = '0;
`ifdef QSPI_RESPONDER_FAST_READ_EN
                    fast_n    = 1'b0;
`endif
                end
            end
            S_COMMAND: begin
                if (sck_rise) begin
                    cmd_n     = cmd_in[6:0];
                    bit_cnt_n = bit_cnt + 5'd1;
                    if (bit_cnt == 5'(CMD_BITS - 1)) begin
                        bit_cnt_n = '0;
                        if (cmd_in == CMD_READ) begin
                            state_n = S_ADDRESS;
`ifdef QSPI_RESPONDER_FAST_READ_EN
                        end else if (cmd_in == CMD_FAST_READ) begin
                            state_n = S_ADDRESS;
                            fast_n  = 1'b1;
`endif
                        end else begin
                            state_n     = S_IGNORE;
                            cmd_error_n = 1'b1;
                        end
                    end
                end
            end
            S_ADDRESS: begin
                if (sck_rise) begin
                    addr_n    = addr_in;
                    bit_cnt_n = bit_cnt + 5'd1;
                    if (bit_cnt == 5'(ADDR_BITS - 1)) begin
                        bit_cnt_n = '0;
                        if (to_dummy) begin
                            state_n = S_DUMMY;
                        end else begin
                            state_n      = S_DATA;
                            sram_csb1_n  = 1'b0;
                            sram_addr1_n = addr_in[AW-1:2];
                        end
                    end
                end
            end
`ifdef QSPI_RESPONDER_FAST_READ_EN
            S_DUMMY: begin
                if (sck_rise) begin
                    bit_cnt_n = bit_cnt + 5'd1;
                    if (bit_cnt == 5'(DUMMY_BITS - 1)) begin
                        bit_cnt_n    = '0;
                        state_n      = S_DATA;
                        sram_csb1_n  = 1'b0;
                        sram_addr1_n = addr[AW-1:2];
                    end
                end
            end
`endif
            S_DATA: begin
                if (sck_fall)
                    io1_write_n = tx_byte[3'd7 - bit_cnt[2:0]];
                if (sck_rise) begin
                    bit_cnt_n = bit_cnt + 5'd1;
                    if (bit_cnt == 5'd7) begin
                        bit_cnt_n = '0;
                        addr_n    = addr_inc;
                        // Fetch the next word as the last lane finishes
                        if (addr[1:0] == 2'b11) begin
                            sram_csb1_n  = 1'b0;
                            sram_addr1_n = addr_inc[AW-1:2];
                        end
                    end
                end
            end
            S_IGNORE: begin
            end
            default: state_n = S_IDLE;
        endcase
        if (csb_s) begin
            state_n     = S_IDLE;
            sram_csb1_n = 1'b1;
        end
        io1_we_n = (state_n == S_DATA);
        if (!io1_we_n)
            io1_write_n = 1'b0;
    end

endmodule

// File: tb/tb_qspi_flash_responder.sv
// Self-checking bench: vector table of flash transactions with a byte
// scoreboard, plus hand sequences for wrap, abort and mid-transfer reset.
module tb_qspi_flash_responder;

    localparam int HP = 5;

    logic        clk = 1'b0;
    logic        wb_rst_i;
    logic        flash_csb;
    logic        flash_sck;
    logic        flash_io0_read;
    logic        flash_io1_we;
    logic        flash_io1_write;
    logic        sram_clk1;
    logic        sram_csb1;
    logic [8:0]  sram_addr1;
    logic [31:0] sram_dout1;
    logic        cmd_error;

    logic [31:0] mem [0:511];

    int n_checks = 0;
    int n_err    = 0;
    int err_cycles = 0;
    int rd_cycles  = 0;
    int we_cycles  = 0;

    logic [7:0] exp_q [$];

    typedef struct {
        logic [7:0]  cmd;
        logic [23:0] addr;
        int          ndummy;
        int          nbytes;
        bit          exp_err;
        logic [31:0] exp_bytes;
        string       name;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    qspi_flash_responder #(.SRAM_ADDRESS_SIZE(9)) dut (
        .wb_clk_i        (clk),
        .wb_rst_i        (wb_rst_i),
        .flash_csb       (flash_csb),
        .flash_sck       (flash_sck),
        .flash_io0_read  (flash_io0_read),
        .flash_io1_we    (flash_io1_we),
        .flash_io1_write (flash_io1_write),
        .sram_clk1       (sram_clk1),
        .sram_csb1       (sram_csb1),
        .sram_addr1      (sram_addr1),
        .sram_dout1      (sram_dout1),
        .cmd_error       (cmd_error)
    );

    always @(posedge sram_clk1)
        if (!sram_csb1)
            sram_dout1 <= mem[sram_addr1];

    always @(negedge clk) begin
        if (cmd_error)     err_cycles <= err_cycles + 1;
        if (!sram_csb1)    rd_cycles  <= rd_cycles + 1;
        if (flash_io1_we)  we_cycles  <= we_cycles + 1;
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic bit_clk(input logic b, output logic rx);
        flash_io0_read = b;
        repeat (HP) @(negedge clk);
        rx = flash_io1_write;
        flash_sck = 1'b1;
        repeat (HP) @(negedge clk);
        flash_sck = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        logic rx;
        for (int i = n - 1; i >= 0; i--)
            bit_clk(v[i], rx);
    endtask

    task automatic recv_byte(input string nm, input bit cmp);
        logic [7:0] bv;
        logic       rx;
        logic [7:0] e;
        for (int i = 7; i >= 0; i--) begin
            bit_clk(1'b0, rx);
            bv[i] = rx;
        end
        if (cmp) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL %s: got byte %0h expected none queued", nm, bv);
            end else begin
                e = exp_q.pop_front();
                check({nm, "_byte"}, {24'h0, bv}, {24'h0, e});
            end
        end
    endtask

    task automatic run_xfer(input logic [7:0] cmd, input logic [23:0] addr,
                            input int ndummy, input int nbytes,
                            input bit exp_err, input string nm);
        int err0;
        int we0;
        err0 = err_cycles;
        we0  = we_cycles;
        flash_csb = 1'b0;
        repeat (4) @(negedge clk);
        send_bits({24'h0, cmd}, 8);
        send_bits({8'h0, addr}, 24);
        if (ndummy > 0)
            send_bits(32'h0, ndummy);
        for (int b = 0; b < nbytes; b++)
            recv_byte(nm, !exp_err);
        flash_csb = 1'b1;
        repeat (6) @(negedge clk);
        check({nm, "_err_pulse"}, err_cycles - err0, exp_err ? 1 : 0);
        if (exp_err)
            check({nm, "_we_quiet"}, we_cycles - we0, 0);
        check({nm, "_we_off"}, {31'h0, flash_io1_we}, 0);
        check({nm, "_queue_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        int rd0;
        int we0;
        int err0;
        logic rx;

        for (int i = 0; i < 512; i++)
            mem[i] = 32'h0;
        mem[0] = 32'h44332211;
        mem[1] = 32'h88776655;

        vecs[0] = '{8'h03, 24'h000000, 0, 4, 1'b0, 32'h11223344, "rd0"};
        vecs[1] = '{8'h03, 24'h000001, 0, 3, 1'b0, 32'h22334400, "rd1"};
        vecs[2] = '{8'h03, 24'h000003, 0, 2, 1'b0, 32'h44550000, "rd_cross"};
        vecs[3] = '{8'h03, 24'h000004, 0, 4, 1'b0, 32'h55667788, "rd_w1"};
        vecs[4] = '{8'h03, 24'h123804, 0, 2, 1'b0, 32'h55660000, "rd_alias"};
        vecs[5] = '{8'h9F, 24'h000000, 0, 1, 1'b1, 32'h0, "bad_9f"};
`ifdef QSPI_RESPONDER_FAST_READ_EN
        vecs[6] = '{8'h0B, 24'h000000, 8, 1, 1'b0, 32'h11000000, "fast"};
`else
        vecs[6] = '{8'h0B, 24'h000000, 8, 1, 1'b1, 32'h0, "fast_off"};
`endif
        vecs[7] = '{8'h03, 24'h000000, 0, 1, 1'b0, 32'h11000000, "rd_after"};

        wb_rst_i       = 1'b1;
        flash_csb      = 1'b1;
        flash_sck      = 1'b0;
        flash_io0_read = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_we",    {31'h0, flash_io1_we},    0);
        check("rst_write", {31'h0, flash_io1_write}, 0);
        check("rst_csb1",  {31'h0, sram_csb1},       1);
        check("rst_addr1", {23'h0, sram_addr1},      0);
        check("rst_err",   {31'h0, cmd_error},       0);
        wb_rst_i = 1'b0;
        repeat (8) @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            if (!vecs[v].exp_err)
                for (int b = 0; b < vecs[v].nbytes; b++)
                    exp_q.push_back(vecs[v].exp_bytes[31 - 8*b -: 8]);
            run_xfer(vecs[v].cmd, vecs[v].addr, vecs[v].ndummy,
                     vecs[v].nbytes, vecs[v].exp_err, vecs[v].name);
        end

        // Wrap from the top byte back to byte 0
        mem[511] = 32'hAA000000;
        mem[0]   = 32'h000000BB;
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'hBB);
        run_xfer(8'h03, 24'h0007FF, 0, 2, 1'b0, "wrap");
        mem[0] = 32'h44332211;

        // Abort after 12 address bits
        rd0  = rd_cycles;
        err0 = err_cycles;
        flash_csb = 1'b0;
        repeat (4) @(negedge clk);
        send_bits(32'h03, 8);
        send_bits(32'h000, 12);
        flash_csb = 1'b1;
        repeat (8) @(negedge clk);
        check("abort_no_read", rd_cycles - rd0, 0);
        check("abort_no_err", err_cycles - err0, 0);
        exp_q.push_back(8'h55);
        exp_q.push_back(8'h66);
        exp_q.push_back(8'h77);
        exp_q.push_back(8'h88);
        run_xfer(8'h03, 24'h000004, 0, 4, 1'b0, "post_abort");

        // Reset in the middle of the data phase
        flash_csb = 1'b0;
        repeat (4) @(negedge clk);
        send_bits(32'h03, 8);
        send_bits(32'h0, 24);
        for (int i = 0; i < 3; i++)
            bit_clk(1'b0, rx);
        check("mid_we_on", {31'h0, flash_io1_we}, 1);
        wb_rst_i = 1'b1;
        @(negedge clk);
        check("mid_rst_we",   {31'h0, flash_io1_we}, 0);
        check("mid_rst_csb1", {31'h0, sram_csb1},    1);
        wb_rst_i = 1'b0;
        rd0  = rd_cycles;
        we0  = we_cycles;
        err0 = err_cycles;
        send_bits(32'h03, 8);
        send_bits(32'h0, 16);
        check("stale_no_we",   we_cycles - we0,   0);
        check("stale_no_read", rd_cycles - rd0,   0);
        check("stale_no_err",  err_cycles - err0, 0);
        flash_csb = 1'b1;
        repeat (8) @(negedge clk);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        run_xfer(8'h03, 24'h000000, 0, 2, 1'b0, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
